// File: rtl/simple_bus_pkg.sv
// Shared types and constants for the simple_bus slave-side memory.
package simple_bus_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    MODE_READ    = 2'b00,
    MODE_WRITE   = 2'b01,
    MODE_BURST   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT,
    RESP,
    BURST
  } slave_state_e;

endpackage

// File: rtl/simple_bus_mem_array.sv
// 256 x 8 single-port array: synchronous write, registered read, async reset init.
module simple_bus_mem_array
  import simple_bus_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= INIT_VAL;
      end
      rdata <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/simple_bus_mem_slave.sv
// simple_bus slave: req/gnt/start/rdy handshake FSM in front of a 256 x 8 memory.
module simple_bus_mem_slave
  import simple_bus_pkg::*;
#(
  parameter int unsigned       WAIT_STATES = 1,
  parameter int unsigned       BURST_LEN   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL    = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_i,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  output logic              err
);

  slave_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        beat_q, beat_d;
  logic              err_q, err_d;
  logic              load;
  logic [ADDR_W-1:0] cmd_addr_q;
  mode_e             cmd_mode_q;
  logic [DATA_W-1:0] cmd_data_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      cmd_addr_q <= '0;
      cmd_mode_q <= MODE_READ;
      cmd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      if (load) begin
        cmd_addr_q <= addr;
        cmd_mode_q <= mode_e'(mode);
        cmd_data_q <= data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) state_d = GRANT;
      end
      GRANT: begin
        beat_d = '0;
        if (!req) begin
          state_d = IDLE;
        end else if (start) begin
          if (mode_e'(mode) == MODE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            load = 1'b1;
            if (WAIT_STATES == 0) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (!req) begin
          state_d = IDLE;
          err_d   = 1'b1;
          beat_d  = '0;
        end else if (cmd_mode_q == MODE_BURST) begin
          state_d = BURST;
          beat_d  = 4'd1;
        end else begin
          state_d = GRANT;
        end
      end
      BURST: begin
        if (!req) begin
          state_d = IDLE;
          err_d   = 1'b1;
          beat_d  = '0;
        end else if (beat_q == 4'(BURST_LEN - 1)) begin
          state_d = GRANT;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read port is addressed with the beat about to be presented, so the
  // registered read data lines up with the rdy cycle that follows.
  assign mem_we   = (state_q == RESP) && (cmd_mode_q == MODE_WRITE);
  assign mem_addr = (state_q == GRANT) ? addr : cmd_addr_q + ADDR_W'(beat_d);

  simple_bus_mem_array #(
    .INIT_VAL(INIT_VAL)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (cmd_data_q),
    .rdata (mem_rdata)
  );

  assign gnt     = (state_q != IDLE);
  assign rdy     = (state_q == RESP) || (state_q == BURST);
  assign data_oe = rdy && (cmd_mode_q != MODE_WRITE);
  assign data_o  = data_oe ? mem_rdata : '0;
  assign err     = err_q;

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Bench for simple_bus_mem_slave: two instances (WAIT_STATES 1 and 3) against an array model.
module tb_simple_bus_mem_slave;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_i = 8'h00;
  int         sel = 0;

  logic       req_a, start_a, gnt_a, rdy_a, oe_a, err_a;
  logic       req_b, start_b, gnt_b, rdy_b, oe_b, err_b;
  logic [7:0] do_a, do_b;
  logic       gnt, rdy, oe, err;
  logic [7:0] dout;

  assign req_a   = (sel == 0) && req;
  assign start_a = (sel == 0) && start;
  assign req_b   = (sel == 1) && req;
  assign start_b = (sel == 1) && start;
  assign gnt  = (sel == 0) ? gnt_a : gnt_b;
  assign rdy  = (sel == 0) ? rdy_a : rdy_b;
  assign oe   = (sel == 0) ? oe_a  : oe_b;
  assign err  = (sel == 0) ? err_a : err_b;
  assign dout = (sel == 0) ? do_a  : do_b;

  simple_bus_mem_slave #(.WAIT_STATES(1), .BURST_LEN(BL), .INIT_VAL(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .start(start_a), .addr(addr), .mode(mode),
    .data_i(data_i), .gnt(gnt_a), .rdy(rdy_a), .data_o(do_a), .data_oe(oe_a), .err(err_a));

  simple_bus_mem_slave #(.WAIT_STATES(3), .BURST_LEN(BL), .INIT_VAL(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .start(start_b), .addr(addr), .mode(mode),
    .data_i(data_i), .gnt(gnt_b), .rdy(rdy_b), .data_o(do_b), .data_oe(oe_b), .err(err_b));

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;
  logic [7:0] ref_mem [2][256];

  int mon_lat, mon_last, mon_nrdy, mon_noe, mon_nerr, mon_gnt_low;
  logic [7:0] mon_beats [16];

  function automatic int ws_of(input int s);
    return (s == 1) ? 3 : 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) ref_mem[s][i] = 8'h00;
  endtask

  task automatic acquire();
    req = 1'b1;
    for (int i = 0; i < 8 && !gnt; i++) step();
    checks++;
    if (gnt !== 1'b1) $display("FAIL acquire sel=%0d: gnt=%b required 1", sel, gnt);
    else passes++;
  endtask

  task automatic switch_to(input int s);
    req = 1'b0;
    step();
    step();
    sel = s;
    acquire();
  endtask

  // Issues one start and watches a fixed window; optionally drives a second start one cycle later.
  task automatic run_txn(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                         input bit ign, input logic [1:0] m2, input logic [7:0] a2,
                         input logic [7:0] d2);
    mode = m; addr = a; data_i = d; start = 1'b1;
    step();
    start = 1'b0;
    mon_lat = -1; mon_last = -1; mon_nrdy = 0; mon_noe = 0; mon_nerr = 0; mon_gnt_low = 0;
    for (int i = 1; i <= 12; i++) begin
      if (rdy === 1'b1) begin
        if (mon_lat < 0) mon_lat = i;
        mon_last = i;
        mon_nrdy++;
        if (oe === 1'b1 && mon_noe < 16) begin
          mon_beats[mon_noe] = dout;
          mon_noe++;
        end
      end
      if (err === 1'b1) mon_nerr++;
      if (gnt !== 1'b1) mon_gnt_low++;
      if (i == 1 && ign) begin
        mode = m2; addr = a2; data_i = d2; start = 1'b1;
      end
      step();
      start = 1'b0;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    run_txn(2'b01, a, d, 1'b0, 2'b00, 8'h00, 8'h00);
    ref_mem[sel][a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      checks++;
      if ({gnt, rdy, oe, err, dout} !== 12'h000)
        $display("FAIL reset_outputs sel=%0d: gnt/rdy/oe/err/data=%b%b%b%b/%h required 0000/00",
                 s, gnt, rdy, oe, err, dout);
      else passes++;
    end
    sel = 0;
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 1'b0) $display("FAIL idle_no_req: gnt=%b required 0", gnt);
    else passes++;
  endtask

  task automatic test_idle_start();
    int nrdy;
    req = 1'b1; start = 1'b1; mode = 2'b00; addr = 8'h00;
    #1;
    checks++;
    if (gnt !== 1'b0) $display("FAIL gnt_before_edge: gnt=%b required 0", gnt);
    else passes++;
    step();
    start = 1'b0;
    checks++;
    if (gnt !== 1'b1) $display("FAIL gnt_rise: gnt=%b required 1", gnt);
    else passes++;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy === 1'b1) nrdy++;
      step();
    end
    checks++;
    if (nrdy != 0) $display("FAIL idle_start_ignored: rdy count=%0d required 0", nrdy);
    else passes++;
  endtask

  task automatic test_write_read();
    run_txn(2'b01, 8'h10, 8'hA5, 1'b0, 2'b00, 8'h00, 8'h00);
    ref_mem[sel][8'h10] = 8'hA5;
    checks++;
    if (mon_lat != 2 || mon_nrdy != 1 || mon_noe != 0 || mon_nerr != 0)
      $display("FAIL write_txn: lat=%0d rdy=%0d oe=%0d err=%0d required 2/1/0/0",
               mon_lat, mon_nrdy, mon_noe, mon_nerr);
    else passes++;
    run_txn(2'b00, 8'h10, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    checks++;
    if (mon_lat != 2 || mon_nrdy != 1 || mon_noe != 1)
      $display("FAIL read_txn: lat=%0d rdy=%0d oe=%0d required 2/1/1", mon_lat, mon_nrdy, mon_noe);
    else passes++;
    checks++;
    if (mon_noe < 1 || mon_beats[0] !== 8'hA5)
      $display("FAIL read_data: got %h required a5", mon_beats[0]);
    else passes++;
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    preload(8'hFE, 8'h11);
    preload(8'hFF, 8'h22);
    preload(8'h00, 8'h33);
    preload(8'h01, 8'h44);
    run_txn(2'b10, 8'hFE, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    checks++;
    if (mon_nrdy != BL || mon_noe != BL || mon_lat != 2 || mon_last - mon_lat + 1 != BL)
      $display("FAIL burst_shape: rdy=%0d oe=%0d first=%0d last=%0d required 4/4/2/5",
               mon_nrdy, mon_noe, mon_lat, mon_last);
    else passes++;
    for (int k = 0; k < BL; k++) begin
      checks++;
      if (k >= mon_noe || mon_beats[k] !== exp_b[k])
        $display("FAIL burst_beat%0d: got %h required %h", k, mon_beats[k], exp_b[k]);
      else passes++;
    end
  endtask

  task automatic test_illegal();
    run_txn(2'b11, 8'h20, 8'h5A, 1'b0, 2'b00, 8'h00, 8'h00);
    checks++;
    if (mon_nerr != 1 || mon_nrdy != 0 || mon_gnt_low != 0)
      $display("FAIL illegal_mode: err=%0d rdy=%0d gnt_low=%0d required 1/0/0",
               mon_nerr, mon_nrdy, mon_gnt_low);
    else passes++;
    run_txn(2'b00, 8'h20, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    checks++;
    if (mon_noe != 1 || mon_beats[0] !== ref_mem[sel][8'h20])
      $display("FAIL illegal_mem: got %h required %h", mon_beats[0], ref_mem[sel][8'h20]);
    else passes++;
  endtask

  task automatic test_ignored_start();
    preload(8'h40, 8'h9C);
    preload(8'h41, 8'h3E);
    run_txn(2'b00, 8'h40, 8'h00, 1'b1, 2'b01, 8'h41, 8'hFF);
    checks++;
    if (mon_nrdy != 1 || mon_noe != 1 || mon_lat != 4 || mon_nerr != 0)
      $display("FAIL ignored_start: rdy=%0d oe=%0d lat=%0d err=%0d required 1/1/4/0",
               mon_nrdy, mon_noe, mon_lat, mon_nerr);
    else passes++;
    checks++;
    if (mon_beats[0] !== 8'h9C) $display("FAIL ignored_start_data: got %h required 9c", mon_beats[0]);
    else passes++;
    run_txn(2'b00, 8'h41, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    checks++;
    if (mon_beats[0] !== 8'h3E) $display("FAIL ignored_start_mem: got %h required 3e", mon_beats[0]);
    else passes++;
  endtask

  task automatic test_abort();
    int nrdy;
    mode = 2'b01; addr = 8'h30; data_i = 8'h77; start = 1'b1;
    step();
    start = 1'b0;
    req = 1'b0;
    step();
    checks++;
    if (err !== 1'b1 || gnt !== 1'b0 || rdy !== 1'b0 || oe !== 1'b0)
      $display("FAIL abort_cycle: err/gnt/rdy/oe=%b%b%b%b required 1000", err, gnt, rdy, oe);
    else passes++;
    nrdy = 0;
    step();
    checks++;
    if (err !== 1'b0) $display("FAIL abort_err_pulse: err=%b required 0", err);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      if (rdy === 1'b1) nrdy++;
      step();
    end
    checks++;
    if (nrdy != 0) $display("FAIL abort_no_rdy: rdy count=%0d required 0", nrdy);
    else passes++;
    acquire();
    run_txn(2'b00, 8'h30, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    checks++;
    if (mon_noe != 1 || mon_beats[0] !== 8'h00)
      $display("FAIL abort_not_committed: got %h required 00", mon_beats[0]);
    else passes++;
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [7:0] a, d;
    int ws, exp_rdy;
    ws = ws_of(sel);
    for (int t = 0; t < 14; t++) begin
      m = 2'($urandom_range(0, 3));
      a = 8'(8'hF8 + $urandom_range(0, 15));
      d = 8'($urandom);
      run_txn(m, a, d, 1'b0, 2'b00, 8'h00, 8'h00);
      exp_rdy = (m == 2'b11) ? 0 : (m == 2'b10) ? BL : 1;
      checks++;
      if (mon_nrdy != exp_rdy || mon_nerr != ((m == 2'b11) ? 1 : 0) ||
          (exp_rdy > 0 && mon_lat != ws + 1))
        $display("FAIL rand_shape sel=%0d mode=%b: rdy=%0d err=%0d lat=%0d required %0d/%0d/%0d",
                 sel, m, mon_nrdy, mon_nerr, mon_lat, exp_rdy, (m == 2'b11) ? 1 : 0, ws + 1);
      else passes++;
      if (m == 2'b01) begin
        ref_mem[sel][a] = d;
      end else if (m != 2'b11) begin
        for (int k = 0; k < exp_rdy; k++) begin
          checks++;
          if (k >= mon_noe || mon_beats[k] !== ref_mem[sel][8'(a + k)])
            $display("FAIL rand_data sel=%0d addr=%h beat%0d: got %h required %h",
                     sel, a, k, mon_beats[k], ref_mem[sel][8'(a + k)]);
          else passes++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    preload(8'h50, 8'hC1);
    preload(8'h52, 8'hC3);
    mode = 2'b10; addr = 8'h50; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      if (rdy === 1'b1) n++;
      if (n < 2) step();
    end
    checks++;
    if (n != 2) $display("FAIL midburst_reach_beat2: beats seen=%0d required 2", n);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, rdy, oe, err, dout} !== 12'h000)
      $display("FAIL async_reset: gnt/rdy/oe/err/data=%b%b%b%b/%h required 0000/00",
               gnt, rdy, oe, err, dout);
    else passes++;
    model_reset();
    req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 1'b0) $display("FAIL idle_after_reset: gnt=%b required 0", gnt);
    else passes++;
    acquire();
    run_txn(2'b10, 8'h50, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    for (int k = 0; k < BL; k++) begin
      checks++;
      if (k >= mon_noe || mon_beats[k] !== ref_mem[sel][8'(8'h50 + k)])
        $display("FAIL reinit_beat%0d: got %h required %h", k, mon_beats[k],
                 ref_mem[sel][8'(8'h50 + k)]);
      else passes++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_start();
    test_write_read();
    test_burst_wrap();
    test_illegal();
    test_random();
    switch_to(1);
    test_ignored_start();
    test_abort();
    test_random();
    switch_to(0);
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, passed=%0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
